// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a ready-handshaked data-memory port and
// owns the MEM/WB registers, stalling upstream while an access is outstanding.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem_valid_i,
    input  logic [31:0] ex_mem_alu_result_i,
    input  logic [31:0] ex_mem_store_data_i,
    input  logic [2:0]  ex_mem_funct3_i,
    input  logic        ex_mem_memread_i,
    input  logic        ex_mem_memwrite_i,
    input  logic        ex_mem_regwrite_i,
    input  logic        ex_mem_memtoreg_i,
    input  logic [4:0]  ex_mem_rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        wb_regwrite_o,
    output logic        wb_memtoreg_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_alu_result_o,
    output logic [31:0] wb_load_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t           state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;

    logic        mem_op;
    logic        misalign_now;
    logic        timeout_abort;
    logic        load_done;
    logic [1:0]  off;

    logic        vld_p1;
    logic        regwrite_p1;
    logic        memtoreg_p1;
    logic [4:0]  rd_p1;
    logic [31:0] alu_result_p1;
    logic [31:0] load_data_p1;
    logic        misalign_p1;
    logic        bus_err_p1;

    // funct3[1:0] encodes the size; the undefined codes 011/110/111 fall into word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return o[0];
            default: return (o != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b00:   return 4'b0001 << o;
            2'b01:   return o[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {o, 3'b000};
        b       = shifted[7:0];
        h       = shifted[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return rdata;
        endcase
    endfunction

    assign off           = ex_mem_alu_result_i[1:0];
    assign mem_op        = ex_mem_valid_i & (ex_mem_memread_i | ex_mem_memwrite_i);
    assign misalign_now  = mem_op & is_misaligned(ex_mem_funct3_i, off);

    // Request is gated by rst_n so it drops the instant reset asserts, even mid-access.
    assign dmem_req_o    = rst_n & ((state_r == WAIT) | (mem_op & ~misalign_now));
    assign timeout_abort = (state_r == WAIT) & ~dmem_ready_i & (cnt_r == TIMEOUT_CNT);
    assign stall_o       = dmem_req_o & ~dmem_ready_i & ~timeout_abort;
    assign load_done     = dmem_req_o & dmem_ready_i & ex_mem_memread_i;

    assign dmem_we_o     = dmem_req_o & ex_mem_memwrite_i;
    assign dmem_be_o     = dmem_req_o ? lane_be(ex_mem_funct3_i, off) : 4'b0000;
    assign dmem_addr_o   = {ex_mem_alu_result_i[31:2], 2'b00};
    assign dmem_wdata_o  = lane_wdata(ex_mem_funct3_i, ex_mem_store_data_i);

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        case (state_r)
            IDLE: begin
                if (dmem_req_o && !dmem_ready_i) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (dmem_ready_i || timeout_abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    // ---- MEM/WB boundary: a stalled cycle inserts a bubble into WB ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            regwrite_p1   <= 1'b0;
            memtoreg_p1   <= 1'b0;
            rd_p1         <= '0;
            alu_result_p1 <= '0;
            load_data_p1  <= '0;
            misalign_p1   <= 1'b0;
            bus_err_p1    <= 1'b0;
        end else if (stall_o) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            misalign_p1 <= 1'b0;
            bus_err_p1  <= 1'b0;
        end else begin
            vld_p1        <= ex_mem_valid_i;
            regwrite_p1   <= ex_mem_valid_i & ex_mem_regwrite_i & ~misalign_now & ~timeout_abort;
            memtoreg_p1   <= ex_mem_memtoreg_i;
            rd_p1         <= ex_mem_rd_i;
            alu_result_p1 <= ex_mem_alu_result_i;
            load_data_p1  <= load_done ? load_extend(ex_mem_funct3_i, off, dmem_rdata_i) : 32'd0;
            misalign_p1   <= misalign_now;
            bus_err_p1    <= timeout_abort;
        end
    end

    assign wb_valid_o      = vld_p1;
    assign wb_regwrite_o   = regwrite_p1;
    assign wb_memtoreg_o   = memtoreg_p1;
    assign wb_rd_o         = rd_p1;
    assign wb_alu_result_o = alu_result_p1;
    assign wb_load_data_o  = load_data_p1;
    assign misalign_o      = misalign_p1;
    assign bus_err_o       = bus_err_p1;

endmodule
